// File: rtl/hbm_write_scheduler_pkg.sv
// Shared types for the HBM write scheduler: FSM states, latched job descriptor,
// AXI response encoding and the engine address width.
package hbm_sched_pkg;

    localparam int HBM_ADDR_W = 33;
    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0]           ops;
        logic [31:0]           stride;
        logic [HBM_ADDR_W-1:0] addr;
        logic [15:0]           burst;
        logic                  is_auto;
    } desc_t;

endpackage

// File: rtl/hbm_write_scheduler_if.sv
// Requester, engine-config, B-snoop and completion signals of the write scheduler.
// slave = scheduler side, master = surrounding requesters/engine/consumer.
interface hbm_write_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 33
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*32-1:0]         req_write_ops;
    logic [NUM_REQ*32-1:0]         req_stride;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_init_addr;
    logic [NUM_REQ*16-1:0]         req_burst_size;
    logic [NUM_REQ-1:0]            req_auto;

    logic                          start_write;
    logic [31:0]                   write_ops;
    logic [31:0]                   stride;
    logic [ADDR_WIDTH-1:0]         init_addr;
    logic [15:0]                   mem_burst_size;
    logic                          is_auto_write;

    logic                          bvalid;
    logic                          bready;
    logic [1:0]                    bresp;

    logic                          done_valid;
    logic [IDX_W-1:0]              done_id;
    logic                          done_err;
    logic                          done_ready;
    logic                          busy;

    modport slave (
        input  req_valid, req_write_ops, req_stride, req_init_addr, req_burst_size, req_auto,
        output req_ready,
        output start_write, write_ops, stride, init_addr, mem_burst_size, is_auto_write,
        input  bvalid, bready, bresp,
        output done_valid, done_id, done_err, busy,
        input  done_ready
    );

    modport master (
        output req_valid, req_write_ops, req_stride, req_init_addr, req_burst_size, req_auto,
        input  req_ready,
        input  start_write, write_ops, stride, init_addr, mem_burst_size, is_auto_write,
        output bvalid, bready, bresp,
        input  done_valid, done_id, done_err, busy,
        output done_ready
    );

endinterface

// File: rtl/hbm_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping at NUM_REQ.
module hbm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from ptr upward and take the first valid requester.
    always_comb begin
        int unsigned k;
        logic [IDX_W-1:0] k_idx;
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int unsigned i = 0; i < unsigned'(NUM_REQ); i++) begin
            k = 32'(ptr) + i;
            if (k >= unsigned'(NUM_REQ)) k = k - unsigned'(NUM_REQ);
            k_idx = k[IDX_W-1:0];
            if (en && !any && req[k_idx]) begin
                any        = 1'b1;
                gnt[k_idx] = 1'b1;
                idx        = k_idx;
            end
        end
    end

endmodule

// File: rtl/hbm_write_scheduler.sv
// Shares one HBM write engine between NUM_REQ requesters: round-robin grant,
// config hold + start pulse, B-response counting, per-job done/error report.
module hbm_write_scheduler
    import hbm_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = HBM_ADDR_W,
    parameter int ID_WIDTH     = 5,
    parameter int SETUP_CYCLES = 2
) (
    input logic              clk,
    input logic              rst_n,
    hbm_write_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int SC_W  = $clog2(SETUP_CYCLES + 1);

    if (NUM_REQ < 2 || SETUP_CYCLES < 1 || ID_WIDTH < 1 || ADDR_WIDTH != HBM_ADDR_W) begin : g_param_check
        $error("hbm_write_scheduler: unsupported parameter set");
    end

    state_t             state_q, state_d;
    desc_t              desc_q, grant_desc;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   done_id_q;
    logic               done_err_q;
    logic               err_acc;
    logic [SC_W-1:0]    setup_cnt;
    logic [31:0]        b_cnt;
    logic               b_hs, b_err, last_b;

    hbm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .en  (state_q == IDLE),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    // Descriptor of the requester the arbiter is currently pointing at.
    always_comb begin
        int unsigned sel;
        sel                = 32'(gnt_idx);
        grant_desc.ops     = bus.req_write_ops[sel*32 +: 32];
        grant_desc.stride  = bus.req_stride[sel*32 +: 32];
        grant_desc.addr    = bus.req_init_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        grant_desc.burst   = bus.req_burst_size[sel*16 +: 16];
        grant_desc.is_auto = bus.req_auto[sel];
    end

    assign b_hs   = bus.bvalid & bus.bready;
    assign b_err  = (bus.bresp != BRESP_OKAY);
    // Compare against ops-1 so the final handshake ends the job without a spare cycle
    // and ops=0xFFFFFFFF never needs b_cnt to wrap.
    assign last_b = b_hs && (b_cnt == desc_q.ops - 32'd1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and control outputs.
    always_comb begin
        state_d         = state_q;
        bus.req_ready   = '0;
        bus.start_write = 1'b0;
        bus.done_valid  = 1'b0;
        bus.busy        = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                bus.req_ready = gnt;
                if (gnt_any) state_d = (grant_desc.ops == 32'd0) ? DONE : SETUP;
            end
            SETUP: if (setup_cnt == '0) state_d = START;
            START: begin
                bus.start_write = 1'b1;
                state_d         = RUN;
            end
            RUN:  if (last_b) state_d = DONE;
            DONE: begin
                bus.done_valid = 1'b1;
                if (bus.done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Job datapath: descriptor latch, rr pointer, setup/B counters, error accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            desc_q     <= '0;
            done_id_q  <= '0;
            done_err_q <= 1'b0;
            rr_ptr     <= '0;
            setup_cnt  <= '0;
            b_cnt      <= '0;
            err_acc    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (gnt_any) begin
                    desc_q     <= grant_desc;
                    done_id_q  <= gnt_idx;
                    done_err_q <= (grant_desc.ops == 32'd0);
                    rr_ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    setup_cnt  <= SC_W'(SETUP_CYCLES - 1);
                end
                SETUP: if (setup_cnt != '0) setup_cnt <= setup_cnt - 1'b1;
                START: begin
                    b_cnt   <= '0;
                    err_acc <= 1'b0;
                end
                RUN: if (b_hs) begin
                    b_cnt   <= b_cnt + 32'd1;
                    err_acc <= err_acc | b_err;
                    if (last_b) done_err_q <= err_acc | b_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.write_ops      = desc_q.ops;
    assign bus.stride         = desc_q.stride;
    assign bus.init_addr      = desc_q.addr;
    assign bus.mem_burst_size = desc_q.burst;
    assign bus.is_auto_write  = desc_q.is_auto;
    assign bus.done_id        = done_id_q;
    assign bus.done_err       = done_err_q;

endmodule
